// File: rtl/reg_file_pkg.sv
// Shared constants for the RV32I register file.
package reg_file_pkg;

   localparam int unsigned XlenDefault = 32;
   localparam int unsigned NumRegs     = 32;
   localparam int unsigned AddrW       = 5;
   localparam logic [AddrW-1:0] X0     = '0;

endpackage

// File: rtl/reg_file_if.sv
// Decode-side bus of the register file: two read ports, write port, scoreboard, stall.
interface reg_file_if #(
   parameter int unsigned XLEN = 32
);

   logic [reg_file_pkg::AddrW-1:0] rs1_addr;
   logic [reg_file_pkg::AddrW-1:0] rs2_addr;
   logic [XLEN-1:0]                rs1_data;
   logic [XLEN-1:0]                rs2_data;
   logic                           rs1_used;
   logic                           rs2_used;
   logic                           we;
   logic [reg_file_pkg::AddrW-1:0] rd_addr;
   logic [XLEN-1:0]                rd_data;
   logic                           pend_set;
   logic [reg_file_pkg::AddrW-1:0] pend_addr;
   logic                           hazard;

   modport master (
      output rs1_addr, rs2_addr, rs1_used, rs2_used, we, rd_addr, rd_data, pend_set, pend_addr,
      input  rs1_data, rs2_data, hazard
   );

   modport slave (
      input  rs1_addr, rs2_addr, rs1_used, rs2_used, we, rd_addr, rd_data, pend_set, pend_addr,
      output rs1_data, rs2_data, hazard
   );

endinterface

// File: rtl/mux2_1.sv
// Single-bit 2:1 mux cell: y = s ? b : a.
module mux2_1 (
   input  logic a_i,
   input  logic b_i,
   input  logic s_i,
   output logic y_o
);

   assign y_o = s_i ? b_i : a_i;

endmodule

// File: rtl/rf_word.sv
// Load-enable word register; hold/load selected per bit through a 2:1 mux.
module rf_word #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            load_i,
   input  logic [XLEN-1:0] d_i,
   output logic [XLEN-1:0] q_o
);

   logic [XLEN-1:0] q_q;
   logic [XLEN-1:0] q_d;

   for (genvar i = 0; i < XLEN; i++) begin : g_bit
      mux2_1 u_mux (
         .a_i (q_q[i]),
         .b_i (d_i[i]),
         .s_i (load_i),
         .y_o (q_d[i])
      );
   end

   // Word storage with asynchronous clear.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/reg_file.sv
// 32 x XLEN register file: two combinational read ports with optional write bypass,
// one synchronous write port and a pending-write scoreboard driving the decode stall.
module reg_file import reg_file_pkg::*; #(
   parameter int unsigned XLEN   = XlenDefault,
   parameter bit          BYPASS = 1'b1
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   reg_file_if.slave  rf_io
);

   logic [NumRegs-1:0][XLEN-1:0] regs;
   logic [NumRegs-1:0]           pend_q;
   logic [NumRegs-1:0]           pend_d;
   logic                         byp1;
   logic                         byp2;
   logic                         stall1;
   logic                         stall2;

   // x0 has no storage and always reads as zero.
   assign regs[0] = '0;

   for (genvar i = 1; i < NumRegs; i++) begin : g_word
      rf_word #(
         .XLEN (XLEN)
      ) u_word (
         .clk_i  (clk_i),
         .rst_ni (rst_ni),
         .load_i (rf_io.we && (rf_io.rd_addr == AddrW'(i))),
         .d_i    (rf_io.rd_data),
         .q_o    (regs[i])
      );
   end

   assign byp1 = BYPASS && rf_io.we && (rf_io.rd_addr == rf_io.rs1_addr);
   assign byp2 = BYPASS && rf_io.we && (rf_io.rd_addr == rf_io.rs2_addr);

   // Read ports; outputs forced to zero while reset is held so the bypass cannot leak through.
   always_comb begin
      rf_io.rs1_data = '0;
      rf_io.rs2_data = '0;
      if (rst_ni && (rf_io.rs1_addr != X0)) begin
         rf_io.rs1_data = byp1 ? rf_io.rd_data : regs[rf_io.rs1_addr];
      end
      if (rst_ni && (rf_io.rs2_addr != X0)) begin
         rf_io.rs2_data = byp2 ? rf_io.rd_data : regs[rf_io.rs2_addr];
      end
   end

   // Scoreboard next state: clear on write, then set, so a newly issued producer wins.
   always_comb begin
      pend_d = pend_q;
      if (rf_io.we) begin
         pend_d[rf_io.rd_addr] = 1'b0;
      end
      if (rf_io.pend_set) begin
         pend_d[rf_io.pend_addr] = 1'b1;
      end
      pend_d[X0] = 1'b0;
   end

   // Scoreboard storage.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
      end
   end

   // Stall a used source that is pending, unless the completing write is forwarded this cycle.
   always_comb begin
      stall1 = rf_io.rs1_used && (rf_io.rs1_addr != X0) && pend_q[rf_io.rs1_addr] && !byp1;
      stall2 = rf_io.rs2_used && (rf_io.rs2_addr != X0) && pend_q[rf_io.rs2_addr] && !byp2;
      rf_io.hazard = rst_ni && (stall1 || stall2);
   end

endmodule
